// File: rtl/ifu_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its consumers:
// FSM encoding, reset constants and instruction field bit positions.
package ifu_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Field positions are shared with the decoder so both slice identically.
    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;
    localparam int F3_MSB  = 14;
    localparam int F3_LSB  = 12;
    localparam int F7_MSB  = 31;
    localparam int F7_LSB  = 25;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: reset load, sequential advance by one word,
// and redirect load, with redirect taking priority over advance.
module ifu_pc_reg import ifu_fetch_unit_pkg::*; #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i;
        end else if (advance_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch unit: issues word fetches, holds the returned instruction
// for the decoder, and squashes in-flight fetches when the PC is redirected.
module ifu_fetch_unit import ifu_fetch_unit_pkg::*; #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     fetch_count
);

    fetch_state_e    state_q, state_d;
    logic [31:0]     inst_q, inst_d;
    logic            drop_q, drop_d;
    logic [31:0]     count_q, count_d;
    logic            pc_advance;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_cur;

    assign redirect_target = redirect_pc & ~XLEN'(3);

    ifu_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .advance_i  (pc_advance),
        .redirect_i (redirect_valid),
        .target_i   (redirect_target),
        .pc_o       (pc_cur)
    );

    // Redirect wins over both handshakes; valids are gated only by redirect and reset.
    always_comb begin
        state_d        = state_q;
        inst_d         = inst_q;
        drop_d         = drop_q;
        count_d        = count_q;
        pc_advance     = 1'b0;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        case (state_q)
            ST_REQ: begin
                imem_req_valid = !redirect_valid;
                if (!redirect_valid && imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        inst_d  = imem_rsp_data;
                        state_d = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                inst_valid = !redirect_valid;
                if (redirect_valid) begin
                    state_d = ST_REQ;
                end else if (inst_ready) begin
                    pc_advance = 1'b1;
                    count_d    = count_q + 32'd1;
                    state_d    = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
        if (rst) begin
            imem_req_valid = 1'b0;
            inst_valid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            inst_q  <= NOP_INST;
            drop_q  <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
            count_q <= count_d;
        end
    end

    assign imem_req_addr = pc_cur;
    assign pc            = pc_cur;
    assign inst          = inst_q;
    assign opcode        = inst_q[OPC_MSB:OPC_LSB];
    assign funct3        = inst_q[F3_MSB:F3_LSB];
    assign funct7        = inst_q[F7_MSB:F7_LSB];
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Self-checking bench for ifu_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_ifu_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    int testCount = 0;
    int failCount = 0;

    // Model: where the current fetch transaction stands, plus architectural values.
    bit          mAwait;
    bit          mHold;
    bit          mSquash;
    logic [31:0] mPc;
    logic [31:0] mInst;
    logic [31:0] mCount;

    ifu_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_count    (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic expReq;
        logic expInstV;
        expReq   = !rst && !mHold && !mAwait && !redirect_valid;
        expInstV = !rst && mHold && !redirect_valid;
        checkValue("req_valid", {31'd0, imem_req_valid}, {31'd0, expReq});
        if (expReq) checkValue("req_addr", imem_req_addr, mPc);
        checkValue("inst_valid", {31'd0, inst_valid}, {31'd0, expInstV});
        checkValue("pc", pc, mPc);
        checkValue("inst", inst, mInst);
        checkValue("opcode", {25'd0, opcode}, {25'd0, mInst[6:0]});
        checkValue("funct3", {29'd0, funct3}, {29'd0, mInst[14:12]});
        checkValue("funct7", {25'd0, funct7}, {25'd0, mInst[31:25]});
        checkValue("fetch_count", fetch_count, mCount);
    endtask

    // Advance the model by one clock given the inputs that are being presented.
    task automatic modelStep();
        logic [31:0] target;
        target = redirect_pc & 32'hFFFF_FFFC;
        if (rst) begin
            mAwait = 0; mHold = 0; mSquash = 0;
            mPc = 32'h8000_0000; mInst = 32'h0000_0013; mCount = 0;
        end else if (mHold) begin
            if (redirect_valid) begin
                mPc = target; mHold = 0;
            end else if (inst_ready) begin
                mPc = mPc + 32'd4; mCount = mCount + 32'd1; mHold = 0;
            end
        end else if (mAwait) begin
            if (redirect_valid) begin
                mPc = target;
                mSquash = !imem_rsp_valid;
                if (imem_rsp_valid) mAwait = 0;
            end else if (imem_rsp_valid) begin
                mAwait = 0;
                if (mSquash) mSquash = 0;
                else begin mInst = imem_rsp_data; mHold = 1; end
            end
        end else begin
            if (redirect_valid) mPc = target;
            else if (imem_req_ready) mAwait = 1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic reqRdy, input logic rspV,
                                 input logic [31:0] rspD, input logic instRdy,
                                 input logic redV, input logic [31:0] redPc, input bit doCheck);
        rst = r; imem_req_ready = reqRdy; imem_rsp_valid = rspV; imem_rsp_data = rspD;
        inst_ready = instRdy; redirect_valid = redV; redirect_pc = redPc;
        #1;
        if (doCheck) checkOutput();
        modelStep();
        @(negedge clk);
    endtask

    // Ideal memory and decoder: response exactly one cycle after acceptance.
    task automatic idleCycle(input logic [31:0] data);
        applyStimulus(0, 1, mAwait, data, 1, 0, 32'h0, 1);
    endtask

    task automatic runUntilAwait(input logic [31:0] data);
        for (int k = 0; k < 8 && !mAwait; k++) applyStimulus(0, 1, 0, data, 1, 0, 32'h0, 1);
    endtask

    task automatic runUntilHold(input logic [31:0] data);
        for (int k = 0; k < 8 && !mHold; k++) idleCycle(data);
    endtask

    initial begin
        logic [31:0] heldPc;
        logic [31:0] heldCount;

        // Reset
        applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        applyStimulus(1, 1, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 1);
        checkValue("rst_pc", pc, 32'h8000_0000);
        checkValue("rst_inst", inst, 32'h0000_0013);
        checkValue("rst_count", fetch_count, 32'h0);

        // Streaming with ideal memory and decoder
        rst = 0; imem_req_ready = 1; imem_rsp_valid = 0; inst_ready = 1; redirect_valid = 0;
        #1;
        checkValue("first_addr", imem_req_addr, 32'h8000_0000);
        checkValue("first_req", {31'd0, imem_req_valid}, 32'd1);
        @(negedge clk);
        rst = 1; #1; modelStep(); @(negedge clk);
        for (int i = 0; i < 9; i++) idleCycle(32'h0010_0093);
        checkValue("stream_count", fetch_count, 32'd3);
        checkValue("stream_pc", pc, 32'h8000_000C);

        // Decoder stall while holding an instruction
        runUntilHold(32'h4020_8133);
        heldPc = pc;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 32'h0, 0, 0, 32'h0, 1);
            checkValue("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        checkValue("stall_pc", pc, heldPc);
        checkValue("stall_funct7", {25'd0, funct7}, 32'h20);
        idleCycle(32'h0);
        checkValue("stall_pc_adv", pc, heldPc + 32'd4);

        // Memory stall: request held at a constant address
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 32'h0, 1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) idleCycle(32'h0000_7033);

        // Redirect while waiting; late response is squashed
        runUntilAwait(32'h0);
        applyStimulus(0, 1, 0, 32'h0, 1, 1, 32'h8000_0103, 1);
        applyStimulus(0, 0, 1, 32'hBAD0_0013, 1, 0, 32'h0, 1);
        checkValue("redir_wait_addr", imem_req_addr, 32'h8000_0100);
        checkValue("redir_wait_iv", {31'd0, inst_valid}, 32'd0);
        runUntilAwait(32'h0);
        applyStimulus(0, 1, 1, 32'hBAD1_0013, 1, 1, 32'h8000_0041, 1);
        checkValue("redir_same_addr", imem_req_addr, 32'h8000_0040);

        // Redirect while valid with decoder ready in the same cycle
        runUntilHold(32'h0000_0063);
        heldCount = fetch_count;
        applyStimulus(0, 1, 0, 32'h0, 1, 1, 32'h8000_0202, 1);
        checkValue("redir_valid_count", fetch_count, heldCount);
        checkValue("redir_valid_addr", imem_req_addr, 32'h8000_0200);

        // Reset in WAIT followed by a stale response
        runUntilAwait(32'h0);
        applyStimulus(1, 1, 0, 32'h0, 1, 0, 32'h0, 1);
        applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 1, 0, 32'h0, 1);
        checkValue("stale_pc", pc, 32'h8000_0000);
        checkValue("stale_inst", inst, 32'h0000_0013);
        checkValue("stale_iv", {31'd0, inst_valid}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) != 0,
                          $urandom,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 9) == 0,
                          $urandom,
                          1);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
